key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-003 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 KEY  input  N_KEYS  raw board pushbuttons, active-low (1 = released, 0 = pressed), asynchronous to CLOCK_50, bouncing.
REQ-006 key_pressed  output  N_KEYS  debounced level, active-high (1 = held).
REQ-007 press_pulse  output  N_KEYS  one-cycle strobe on each accepted press; usable directly as a load enable for a downstream SW-capture register.
REQ-008 release_pulse  output  N_KEYS  one-cycle strobe on each accepted release.

Function
REQ-009 Each channel SHALL be fully independent; no shared counter or arbitration between channels.
REQ-010 Each KEY bit SHALL pass through a two-flop synchronizer (sync1, sync2); the FSM SHALL read only sync2.
REQ-011 Each channel SHALL implement a four-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED: sync2 = 0 -> PRESS_WAIT with cnt = 1; otherwise stay.
REQ-013 PRESS_WAIT: sync2 = 1 -> RELEASED, cnt = 0, no pulse (bounce rejected); sync2 = 0 and cnt = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise cnt increments.
REQ-014 PRESSED: sync2 = 1 -> RELEASE_WAIT with cnt = 1; otherwise stay.
REQ-015 RELEASE_WAIT: sync2 = 0 -> PRESSED, cnt = 0, no pulse; sync2 = 1 and cnt = DEBOUNCE_CYCLES-1 -> RELEASED; otherwise cnt increments.
REQ-016 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits; the counter SHALL never wrap; it is cleared on every return to RELEASED or PRESSED.
REQ-017 press_pulse[i] SHALL be registered and high for exactly the one cycle following the PRESS_WAIT -> PRESSED transition edge.
REQ-018 release_pulse[i] SHALL be registered and high for exactly the one cycle following the RELEASE_WAIT -> RELEASED transition edge.
REQ-019 key_pressed[i] SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT, and registered so that it rises on the same edge as press_pulse and falls on the same edge as release_pulse.
REQ-020 Latency: if KEY[i] is first sampled low at edge E0 and stays low, press_pulse[i] and key_pressed[i] SHALL rise at edge E0 + DEBOUNCE_CYCLES + 1; release is symmetric.
REQ-021 A held key SHALL produce exactly one press_pulse regardless of hold duration; no auto-repeat.
REQ-022 press_pulse and release_pulse for the same channel SHALL never be high in the same cycle, and SHALL be separated by at least DEBOUNCE_CYCLES cycles.
REQ-023 Simultaneous activity on several channels SHALL yield pulses in the same cycle when their stimuli are identical.

Reset
REQ-024 While reset_n = 0, asynchronously: sync1 and sync2 SHALL be 1, every FSM SHALL be RELEASED, every cnt SHALL be 0, and key_pressed, press_pulse and release_pulse SHALL be all-zero.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; a key held low across reset deassertion SHALL be re-debounced from scratch and SHALL produce one press_pulse; no release_pulse SHALL be emitted for the reset itself.

Verification (DEBOUNCE_CYCLES = 4, N_KEYS = 4)
REQ-026 Reset: reset_n = 0 with KEY = 4'b0000 -> all outputs 0 for the whole reset period; release reset with KEY = 4'b1111 -> outputs stay 0 for 20 cycles.
REQ-027 Clean press: KEY[0] low from edge E0 for 10 cycles -> press_pulse = 4'b0001 only in the cycle after edge E0+5; key_pressed[0] = 1 from edge E0+5; exactly one pulse.
REQ-028 Bounce rejection: KEY[1] low 3 cycles, high 1, low 2, high 1, then low steadily from edge E1 -> no pulse before edge E1+5; exactly one press_pulse[1] at edge E1+5.
REQ-029 Release with glitch: with channel 2 PRESSED, KEY[2] high 2 cycles then low -> no release_pulse and key_pressed[2] stays 1; then KEY[2] high steadily from edge E2 -> release_pulse[2] at edge E2+5 and key_pressed[2] = 0 from the same edge.
REQ-030 Simultaneous: KEY[0] and KEY[3] driven low on the same edge -> press_pulse = 4'b1001 in a single cycle.
REQ-031 Reset mid-operation: KEY[0] low for 3 cycles, pulse reset_n low 1 cycle, KEY[0] held low -> all outputs 0 during reset; press_pulse[0] at 5 edges after the first post-reset edge; no release_pulse.

Source files
------------

// File: rtl/key_debouncer.sv
// key_debouncer: per-channel synchronizer plus debounce FSM for active-low pushbuttons.
// Each channel owns its own state machine and counter, so channels never interact.
// Outputs are active-high and fully registered.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  // Two-flop synchronizer; resets to the released (high) level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : gen_ch
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          pressed_q;
    logic          press_q;
    logic          release_q;

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES consecutive matching samples.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (!sync2_q[g]) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (sync2_q[g]) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q   <= PRESSED;
              cnt_q     <= '0;
              pressed_q <= 1'b1;
              press_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PRESSED: begin
            if (sync2_q[g]) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (!sync2_q[g]) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_MAX) begin
              state_q   <= RELEASED;
              cnt_q     <= '0;
              pressed_q <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
          end
        endcase
      end
    end

    assign key_pressed[g]   = pressed_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed bench for key_debouncer with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_debouncer;

  logic       clk;
  logic       rstN;
  logic [3:0] key;
  logic [3:0] keyPressed;
  logic [3:0] pressPulse;
  logic [3:0] releasePulse;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  key_debouncer #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(rstN),
    .KEY(key),
    .key_pressed(keyPressed),
    .press_pulse(pressPulse),
    .release_pulse(releasePulse)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] expPP,
                          input logic [3:0] expRP, input logic [3:0] expKP);
    checkOutput({tag, ".press_pulse"}, pressPulse, expPP);
    checkOutput({tag, ".release_pulse"}, releasePulse, expRP);
    checkOutput({tag, ".key_pressed"}, keyPressed, expKP);
  endtask

  // Advance n falling edges, checking all outputs at each one
  task automatic runCycles(input int n, input logic [3:0] expPP, input logic [3:0] expRP,
                           input logic [3:0] expKP, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkAll(tag, expPP, expRP, expKP);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    key = k;
  endtask

  initial begin
    rstN = 1'b0;
    key  = 4'b0000;
    #1;
    checkAll("reset_t0", 4'b0, 4'b0, 4'b0);
    runCycles(5, 4'b0, 4'b0, 4'b0, "in_reset");
    rstN = 1'b1;
    applyStimulus(4'b1111);
    runCycles(20, 4'b0, 4'b0, 4'b0, "post_reset_idle");

    // Clean press and release on channel 0
    applyStimulus(4'b1110);
    runCycles(5, 4'b0, 4'b0, 4'b0, "k0_wait");
    runCycles(1, 4'b0001, 4'b0, 4'b0001, "k0_press");
    runCycles(5, 4'b0, 4'b0, 4'b0001, "k0_hold");
    applyStimulus(4'b1111);
    runCycles(5, 4'b0, 4'b0, 4'b0001, "k0_rel_wait");
    runCycles(1, 4'b0, 4'b0001, 4'b0, "k0_release");
    runCycles(3, 4'b0, 4'b0, 4'b0, "k0_idle");

    // Bouncing press on channel 1
    applyStimulus(4'b1101);
    runCycles(3, 4'b0, 4'b0, 4'b0, "k1_bounce_a");
    applyStimulus(4'b1111);
    runCycles(1, 4'b0, 4'b0, 4'b0, "k1_bounce_b");
    applyStimulus(4'b1101);
    runCycles(2, 4'b0, 4'b0, 4'b0, "k1_bounce_c");
    applyStimulus(4'b1111);
    runCycles(1, 4'b0, 4'b0, 4'b0, "k1_bounce_d");
    applyStimulus(4'b1101);
    runCycles(5, 4'b0, 4'b0, 4'b0, "k1_wait");
    runCycles(1, 4'b0010, 4'b0, 4'b0010, "k1_press");
    runCycles(3, 4'b0, 4'b0, 4'b0010, "k1_hold");
    applyStimulus(4'b1111);
    runCycles(5, 4'b0, 4'b0, 4'b0010, "k1_rel_wait");
    runCycles(1, 4'b0, 4'b0010, 4'b0, "k1_release");
    runCycles(2, 4'b0, 4'b0, 4'b0, "k1_idle");

    // Channel 2: press, glitchy release rejected, then clean release
    applyStimulus(4'b1011);
    runCycles(5, 4'b0, 4'b0, 4'b0, "k2_wait");
    runCycles(1, 4'b0100, 4'b0, 4'b0100, "k2_press");
    runCycles(2, 4'b0, 4'b0, 4'b0100, "k2_hold");
    applyStimulus(4'b1111);
    runCycles(2, 4'b0, 4'b0, 4'b0100, "k2_glitch_hi");
    applyStimulus(4'b1011);
    runCycles(6, 4'b0, 4'b0, 4'b0100, "k2_glitch_lo");
    applyStimulus(4'b1111);
    runCycles(5, 4'b0, 4'b0, 4'b0100, "k2_rel_wait");
    runCycles(1, 4'b0, 4'b0100, 4'b0, "k2_release");
    runCycles(2, 4'b0, 4'b0, 4'b0, "k2_idle");

    // Channels 0 and 3 together
    applyStimulus(4'b0110);
    runCycles(5, 4'b0, 4'b0, 4'b0, "k03_wait");
    runCycles(1, 4'b1001, 4'b0, 4'b1001, "k03_press");
    runCycles(3, 4'b0, 4'b0, 4'b1001, "k03_hold");
    applyStimulus(4'b1111);
    runCycles(5, 4'b0, 4'b0, 4'b1001, "k03_rel_wait");
    runCycles(1, 4'b0, 4'b1001, 4'b0, "k03_release");
    runCycles(2, 4'b0, 4'b0, 4'b0, "k03_idle");

    // Reset in the middle of a press debounce on channel 0
    applyStimulus(4'b1110);
    runCycles(3, 4'b0, 4'b0, 4'b0, "rst_mid_pre");
    rstN = 1'b0;
    runCycles(1, 4'b0, 4'b0, 4'b0, "rst_mid_in");
    rstN = 1'b1;
    runCycles(5, 4'b0, 4'b0, 4'b0, "rst_mid_redeb");
    runCycles(1, 4'b0001, 4'b0, 4'b0001, "rst_mid_press");
    runCycles(3, 4'b0, 4'b0, 4'b0001, "rst_mid_hold");

    // Reset while held: outputs clear asynchronously, no release strobe, then one new press
    rstN = 1'b0;
    #1;
    checkAll("rst_held_async", 4'b0, 4'b0, 4'b0);
    runCycles(1, 4'b0, 4'b0, 4'b0, "rst_held_in");
    rstN = 1'b1;
    runCycles(5, 4'b0, 4'b0, 4'b0, "rst_held_redeb");
    runCycles(1, 4'b0001, 4'b0, 4'b0001, "rst_held_press");
    runCycles(10, 4'b0, 4'b0, 4'b0001, "rst_held_long");
    applyStimulus(4'b1111);
    runCycles(5, 4'b0, 4'b0, 4'b0001, "final_rel_wait");
    runCycles(1, 4'b0, 4'b0001, 4'b0, "final_release");
    runCycles(3, 4'b0, 4'b0, 4'b0, "final_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
